sevenseg_capture: RTL



---
 rtl/sevenseg_pkg.sv | 57 +++++
 rtl/sevenseg_capture_seg_decode.sv | 48 ++++
 rtl/sevenseg_capture.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the seven-segment capture block:
// digit glyph patterns, segment bit positions, geometry and FSM states.
package sevenseg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int CODE_W     = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  // Segment line positions inside an 8-bit ENS word: [7:1] = a..g, [0] = dp
  localparam int SEG_LIT_LSB = 1;
  localparam int SEG_DP_BIT  = 0;
  localparam logic [7:0] DP_MASK = 8'h01 << SEG_DP_BIT;

  // Lit-segment patterns (a..g, a in the MSB) for each glyph
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h4E;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_PUBLISH
  } frame_state_t;

  // Place a 7-bit glyph into its position within an 8-bit ENS word (dp = 0)
  function automatic logic [7:0] seg_pat(input logic [6:0] s);
    return {1'b0, s} << SEG_LIT_LSB;
  endfunction

  function automatic logic is_one_hot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] one_hot_index(input logic [NUM_DIGITS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sevenseg_capture_seg_decode.sv
// Combinational glyph decoder: one captured ENS word -> {code, ok, blank}.
// Define SEVENSEG_CAPTURE_HEX_EN to also recognise the A..F glyphs.
module seg_decode
  import sevenseg_pkg::*;
(
  input  logic [7:0]        pat,
  output logic [CODE_W-1:0] code,
  output logic              ok,
  output logic              blank
);

  logic [7:0] lit;

  // Mask the decimal point, then match the remaining segments against the glyph table
  always_comb begin
    lit   = pat & ~DP_MASK;
    code  = 4'hF;
    ok    = 1'b0;
    blank = 1'b0;
    if (lit == seg_pat(SEG_BLANK)) begin
      code  = 4'h0;
      blank = 1'b1;
    end else begin
      case (lit)
        seg_pat(SEG_0): begin code = 4'h0; ok = 1'b1; end
        seg_pat(SEG_1): begin code = 4'h1; ok = 1'b1; end
        seg_pat(SEG_2): begin code = 4'h2; ok = 1'b1; end
        seg_pat(SEG_3): begin code = 4'h3; ok = 1'b1; end
        seg_pat(SEG_4): begin code = 4'h4; ok = 1'b1; end
        seg_pat(SEG_5): begin code = 4'h5; ok = 1'b1; end
        seg_pat(SEG_6): begin code = 4'h6; ok = 1'b1; end
        seg_pat(SEG_7): begin code = 4'h7; ok = 1'b1; end
        seg_pat(SEG_8): begin code = 4'h8; ok = 1'b1; end
        seg_pat(SEG_9): begin code = 4'h9; ok = 1'b1; end
`ifdef SEVENSEG_CAPTURE_HEX_EN
        seg_pat(SEG_A): begin code = 4'hA; ok = 1'b1; end
        seg_pat(SEG_B): begin code = 4'hB; ok = 1'b1; end
        seg_pat(SEG_C): begin code = 4'hC; ok = 1'b1; end
        seg_pat(SEG_D): begin code = 4'hD; ok = 1'b1; end
        seg_pat(SEG_E): begin code = 4'hE; ok = 1'b1; end
        seg_pat(SEG_F): begin code = 4'hF; ok = 1'b1; end
`endif
        default: begin code = 4'hF; ok = 1'b0; end
      endcase
    end
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Receive side of the 8-digit multiplexed seven-segment driver: samples the
// scanned COM/ENS lines, rebuilds the per-digit patterns, and publishes a
// decoded frame with a one-cycle strobe. Optional macro SEVENSEG_CAPTURE_HEX_EN
// enables A..F glyph decoding in seg_decode.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYC     = 4,
  parameter int TIMEOUT_CYC    = 65536,
  parameter bit COM_ACTIVE_LOW = 1'b0,
  parameter bit ENS_ACTIVE_LOW = 1'b0
) (
  input  logic        iCLK,
  input  logic        nRST,
  input  logic [7:0]  iS_COM,
  input  logic [7:0]  iS_ENS,
  output logic [63:0] oSEG_PAT,
  output logic [31:0] oCODE,
  output logic [7:0]  oCODE_OK,
  output logic [7:0]  oBLANK,
  output logic        oFRAME_VALID,
  output logic        oCHANGED,
  output logic        oDARK
);

  localparam int DWELL_W = $clog2(STABLE_CYC + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(STABLE_CYC);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0]    TO_MAX    = TO_W'(TIMEOUT_CYC);

  logic [7:0] com_q, ens_q, com_prev, ens_prev;
  logic [NUM_DIGITS-1:0] com_n;
  logic [7:0] ens_n;
  logic sample_valid, sample_same, capture, captured_q, timeout_hit, publish;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [TO_W-1:0] to_cnt_q;
  logic [NUM_DIGITS-1:0][7:0] slot_q;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  frame_state_t state_q, state_d;
  logic [NUM_DIGITS-1:0][CODE_W-1:0] dec_code;
  logic [NUM_DIGITS-1:0] dec_ok, dec_blank;

  assign com_n = com_q ^ {8{COM_ACTIVE_LOW}};
  assign ens_n = ens_q ^ {8{ENS_ACTIVE_LOW}};

  // Register the scan lines once, keeping the previous sample for change detection
  always_ff @(posedge iCLK or negedge nRST) begin
    if (!nRST) begin
      com_q    <= '0;
      ens_q    <= '0;
      com_prev <= '0;
      ens_prev <= '0;
    end else begin
      com_q    <= iS_COM;
      ens_q    <= iS_ENS;
      com_prev <= com_q;
      ens_prev <= ens_q;
    end
  end

  // Dwell tracking: count identical one-hot samples, capture once on reaching STABLE_CYC
  always_comb begin
    sample_valid = is_one_hot(com_n);
    sample_same  = (com_q == com_prev) && (ens_q == ens_prev) && (dwell_q != '0);
    dwell_d      = '0;
    if (sample_valid) begin
      if (!sample_same)             dwell_d = DWELL_W'(1);
      else if (dwell_q != DWELL_MAX) dwell_d = dwell_q + 1'b1;
      else                           dwell_d = dwell_q;
    end
    capture     = sample_valid && (dwell_d == DWELL_MAX) && !(sample_same && captured_q);
    timeout_hit = !capture && (to_cnt_q == TO_LAST);
  end

  // Dwell counter, one-capture-per-dwell flag, slot storage and timeout tracking
  always_ff @(posedge iCLK or negedge nRST) begin
    if (!nRST) begin
      dwell_q    <= '0;
      captured_q <= 1'b0;
      slot_q     <= '0;
      to_cnt_q   <= '0;
      oDARK      <= 1'b0;
    end else begin
      dwell_q <= dwell_d;
      if (capture)           captured_q <= 1'b1;
      else if (!sample_same) captured_q <= 1'b0;
      if (capture) slot_q[one_hot_index(com_n)] <= ens_n;
      if (capture)                to_cnt_q <= '0;
      else if (to_cnt_q != TO_MAX) to_cnt_q <= to_cnt_q + 1'b1;
      if (capture)          oDARK <= 1'b0;
      else if (timeout_hit) oDARK <= 1'b1;
    end
  end

  // Frame assembly FSM state register and seen mask
  always_ff @(posedge iCLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      seen_q  <= '0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
    end
  end

  // Next-state: collect digits until all are seen, publish for one cycle; timeout forces idle
  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    publish = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          seen_d  = com_n;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        seen_d = seen_q | (capture ? com_n : '0);
        if (seen_d == '1) state_d = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        publish = 1'b1;
        seen_d  = capture ? com_n : '0;
        state_d = capture ? ST_COLLECT : ST_IDLE;
      end
      default: begin
        seen_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
    if (timeout_hit) begin
      seen_d  = '0;
      state_d = ST_IDLE;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg_decode u_dec (
      .pat  (slot_q[g]),
      .code (dec_code[g]),
      .ok   (dec_ok[g]),
      .blank(dec_blank[g])
    );
  end

  // Published outputs: copy slots and their decodes on publish, otherwise hold
  always_ff @(posedge iCLK or negedge nRST) begin
    if (!nRST) begin
      oSEG_PAT     <= '0;
      oCODE        <= '0;
      oCODE_OK     <= '0;
      oBLANK       <= 8'hFF;
      oFRAME_VALID <= 1'b0;
      oCHANGED     <= 1'b0;
    end else begin
      oFRAME_VALID <= publish;
      if (publish) begin
        oSEG_PAT <= slot_q;
        oCODE    <= dec_code;
        oCODE_OK <= dec_ok;
        oBLANK   <= dec_blank;
        oCHANGED <= (slot_q != oSEG_PAT);
      end
    end
  end

endmodule
